// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit, also used by the
// control unit and the ALU result-select decode.
package muldiv_pkg;

  localparam int N     = 32;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    OP_MUL_LO = 2'b00,
    OP_MUL_HI = 2'b01,
    OP_DIV_Q  = 2'b10,
    OP_DIV_R  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/response bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface iter_muldiv_if;
  import muldiv_pkg::*;

  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);

endinterface

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply/divide: one bit per clock, shift-add multiply
// and restoring divide, held result with a one-cycle done strobe.
module iter_muldiv
  import muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  iter_muldiv_if.slave  bus
);

  state_e           state_reg;
  op_e              op_reg;
  logic [N-1:0]     b_reg;
  logic [N-1:0]     hi_reg;
  logic [N-1:0]     lo_reg;
  logic [N:0]       rem_reg;
  logic [N-1:0]     quot_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [N-1:0]     result_reg;

  logic [N:0]       mul_sum;
  logic [N-1:0]     hi_next;
  logic [N-1:0]     lo_next;
  logic [N+1:0]     rem_shift;
  logic [N+1:0]     trial;
  logic [N:0]       rem_next;
  logic [N-1:0]     quot_next;
  logic             is_div;

  assign is_div     = op_reg[1];
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;

  // One iteration of both datapaths; the FSM picks which one to commit.
  always_comb begin
    mul_sum   = lo_reg[0] ? ({1'b0, hi_reg} + {1'b0, b_reg}) : {1'b0, hi_reg};
    hi_next   = mul_sum[N:1];
    lo_next   = {mul_sum[0], lo_reg[N-1:1]};
    // Extra top bit makes the trial subtraction's sign directly visible.
    rem_shift = {rem_reg, quot_reg[N-1]};
    trial     = rem_shift - {2'b00, b_reg};
    rem_next  = rem_shift[N:0];
    quot_next = {quot_reg[N-2:0], 1'b0};
    if (!trial[N+1]) begin
      rem_next  = trial[N:0];
      quot_next = {quot_reg[N-2:0], 1'b1};
    end
  end

  // Control FSM with registered busy/done/result and datapath state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      op_reg     <= OP_MUL_LO;
      b_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      rem_reg    <= '0;
      quot_reg   <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            op_reg   <= op_e'(bus.op);
            b_reg    <= bus.b;
            hi_reg   <= '0;
            lo_reg   <= bus.a;
            rem_reg  <= '0;
            quot_reg <= bus.a;
            cnt_reg  <= CNT_W'(N - 1);
            if (bus.op[1] && (bus.b == '0)) begin
              // Divide by zero short-circuits straight to the result.
              state_reg  <= S_DONE;
              done_reg   <= 1'b1;
              result_reg <= (op_e'(bus.op) == OP_DIV_Q) ? '1 : bus.a;
            end else begin
              state_reg <= S_RUN;
              busy_reg  <= 1'b1;
            end
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          if (is_div) begin
            rem_reg  <= rem_next;
            quot_reg <= quot_next;
          end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
          end
          if (cnt_reg == '0) begin
            case (op_reg)
              OP_MUL_LO: result_reg <= lo_next;
              OP_MUL_HI: result_reg <= hi_next;
              OP_DIV_Q:  result_reg <= quot_next;
              default:   result_reg <= rem_next[N-1:0];
            endcase
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed and randomized checks of iter_muldiv: results, latency, busy
// duration, done width, mid-run start, back-to-back ops and mid-run reset.
module tb_iter_muldiv;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  iter_muldiv_if bus ();

  iter_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the request is sampled on the next rising edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  // Waits for done after an issue, scrambling inputs to prove they were latched.
  task automatic collect(input string tag, input logic [31:0] exp_res,
                         input int exp_lat, input int pulse_at);
    int cyc   = 0;
    int bcnt  = 0;
    bit seen  = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.a     = ~bus.a;
        bus.b     = bus.b + 32'd3;
        bus.op    = ~bus.op;
      end
      if (pulse_at > 0 && cyc == pulse_at) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end else if (pulse_at > 0 && cyc == pulse_at + 1) begin
        bus.start = 1'b0;
      end
      check({tag, "_overlap"}, {63'd0, bus.busy & bus.done}, 64'd0);
      if (bus.busy) bcnt++;
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
    check({tag, "_result"}, {32'd0, bus.result}, {32'd0, exp_res});
    $display("op %s: result=0x%08h latency=%0d busy=%0d", tag, bus.result, cyc, bcnt);
  endtask

  // Done must drop after exactly one cycle when no new start is given.
  task automatic tail(input string tag);
    @(negedge clk);
    check({tag, "_done_width"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] ra, rb, exp;
    logic [1:0]  rop;
    int          lat;
    int          dcnt;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy",   {63'd0, bus.busy}, 64'd0);
    check("rst_done",   {63'd0, bus.done}, 64'd0);
    check("rst_result", {32'd0, bus.result}, 64'd0);

    @(negedge clk);
    issue(OP_MUL_LO, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect("mul_lo_ff", 32'h0000_0001, 33, 0); tail("mul_lo_ff");
    issue(OP_MUL_HI, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect("mul_hi_ff", 32'hFFFF_FFFE, 33, 0); tail("mul_hi_ff");
    issue(OP_MUL_LO, 32'h0001_0003, 32'h0000_0010); collect("mul_lo_sh", 32'h0010_0030, 33, 0); tail("mul_lo_sh");
    issue(OP_DIV_Q, 32'd100, 32'd7);                collect("divq_100_7", 32'd14, 33, 0);      tail("divq_100_7");
    issue(OP_DIV_R, 32'd100, 32'd7);                collect("divr_100_7", 32'd2, 33, 0);       tail("divr_100_7");
    issue(OP_DIV_Q, 32'd5, 32'd9);                  collect("divq_5_9", 32'd0, 33, 0);         tail("divq_5_9");
    issue(OP_DIV_R, 32'd5, 32'd9);                  collect("divr_5_9", 32'd5, 33, 0);         tail("divr_5_9");
    issue(OP_DIV_Q, 32'h1234_5678, 32'd0);          collect("divq_zero", 32'hFFFF_FFFF, 1, 0); tail("divq_zero");
    issue(OP_DIV_R, 32'h1234_5678, 32'd0);          collect("divr_zero", 32'h1234_5678, 1, 0); tail("divr_zero");

    // Mid-run start is ignored; start in the done cycle launches the next op.
    issue(OP_DIV_Q, 32'd100, 32'd7);
    collect("b2b_first", 32'd14, 33, 5);
    issue(OP_MUL_HI, 32'hFFFF_FFFF, 32'h0000_0002);
    collect("b2b_second", 32'h0000_0001, 33, 0);
    tail("b2b_second");

    // Reset at cycle 10 of a run aborts it with no later done strobe.
    issue(OP_MUL_LO, 32'd3, 32'd5);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy",   {63'd0, bus.busy}, 64'd0);
    check("midrst_done",   {63'd0, bus.done}, 64'd0);
    check("midrst_result", {32'd0, bus.result}, 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    check("midrst_no_done", 64'(dcnt), 64'd0);
    $display("op midrst: aborted, quiet cycles checked");
    issue(OP_DIV_R, 32'd1000, 32'd33); collect("post_rst", 32'd10, 33, 0); tail("post_rst");

    // Randomized operations against an arithmetic reference.
    for (int n = 0; n < 120; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      p = {32'd0, ra} * {32'd0, rb};
      case (rop)
        2'b00:   exp = p[31:0];
        2'b01:   exp = p[63:32];
        2'b10:   exp = (rb == 0) ? 32'hFFFF_FFFF : ra / rb;
        default: exp = (rb == 0) ? ra : ra % rb;
      endcase
      lat = (rop[1] && rb == 0) ? 1 : 33;
      issue(rop, ra, rb);
      collect($sformatf("rnd%0d", n), exp, lat, 0);
      tail($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
